// File: rtl/dual_issue_instr_queue.sv
`default_nettype none
// ============================================================================
// Module   : dual_issue_instr_queue
// Brief    : Circular fetch queue, up to two pushes and two pops per cycle,
//            presenting the head pair to a dual-issue decoder.
// Revision : 1.0 - initial release
// ============================================================================
module dual_issue_instr_queue #(
    parameter int DEPTH_P       = 8,
    parameter int INSTR_WIDTH_P = 32
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic [1:0]                         enq_cnt_i,
    input  logic [1:0][INSTR_WIDTH_P-1:0]      enq_instr_i,
    input  logic [31:0]                        enq_pc_i,
    output logic                               enq_ready_o,
    output logic [1:0][INSTR_WIDTH_P-1:0]      instr_o,
    output logic [31:0]                        pc_o,
    output logic [1:0]                         v_o,
    input  logic [1:0]                         deq_cnt_i,
    input  logic                               flush_i,
    output logic [$clog2(DEPTH_P):0]           count_o,
    output logic                               overflow_o,
    output logic                               underflow_o
);

    localparam int PTR_W = $clog2(DEPTH_P);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [INSTR_WIDTH_P-1:0] c_NOP = INSTR_WIDTH_P'(32'h0000_0013);

    logic [INSTR_WIDTH_P-1:0] r_instr_mem [DEPTH_P];
    logic [31:0]              r_pc_mem    [DEPTH_P];

    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_enq_ready;
    logic             w_enq_illegal;
    logic [1:0]       w_enq_eff;
    logic [CNT_W-1:0] w_deq_req;
    logic             w_underflow_req;
    logic [CNT_W-1:0] w_deq_eff;
    logic [CNT_W-1:0] w_count_next;
    logic [PTR_W-1:0] w_wr_ptr_p1;
    logic [PTR_W-1:0] w_rd_ptr_p1;

    // Readiness depends only on registered occupancy so a same-cycle pop
    // can never open the door for a push.
    always_comb begin
        w_enq_ready     = (r_count <= CNT_W'(DEPTH_P - 2));
        w_enq_illegal   = (enq_cnt_i == 2'd3) || ((enq_cnt_i != 2'd0) && !w_enq_ready);
        w_enq_eff       = w_enq_illegal ? 2'd0 : enq_cnt_i;
        w_deq_req       = {{(CNT_W-2){1'b0}}, deq_cnt_i};
        w_underflow_req = (w_deq_req > r_count);
        w_deq_eff       = w_underflow_req ? r_count : w_deq_req;
        w_count_next    = r_count + CNT_W'(w_enq_eff) - w_deq_eff;
        w_wr_ptr_p1     = r_wr_ptr + PTR_W'(1);
        w_rd_ptr_p1     = r_rd_ptr + PTR_W'(1);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_rd_ptr    <= r_rd_ptr + PTR_W'(w_deq_eff);
            r_wr_ptr    <= r_wr_ptr + PTR_W'(w_enq_eff);
            r_count     <= w_count_next;
            r_overflow  <= r_overflow  | w_enq_illegal;
            r_underflow <= r_underflow | w_underflow_req;
        end
    end

    // Storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk_i) begin
        if (!flush_i && (w_enq_eff != 2'd0)) begin
            r_instr_mem[r_wr_ptr] <= enq_instr_i[0];
            r_pc_mem[r_wr_ptr]    <= enq_pc_i;
            if (w_enq_eff == 2'd2) begin
                r_instr_mem[w_wr_ptr_p1] <= enq_instr_i[1];
                r_pc_mem[w_wr_ptr_p1]    <= enq_pc_i + 32'd4;
            end
        end
    end

    always_comb begin
        v_o[0]      = (r_count >= CNT_W'(1));
        v_o[1]      = (r_count >= CNT_W'(2));
        instr_o[0]  = v_o[0] ? r_instr_mem[r_rd_ptr]    : c_NOP;
        instr_o[1]  = v_o[1] ? r_instr_mem[w_rd_ptr_p1] : c_NOP;
        pc_o        = r_pc_mem[r_rd_ptr];
        enq_ready_o = w_enq_ready;
        count_o     = r_count;
        overflow_o  = r_overflow;
        underflow_o = r_underflow;
    end

endmodule
`default_nettype wire

// File: tb/tb_dual_issue_instr_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_dual_issue_instr_queue
// Brief    : Directed vector table plus hand sequences for the instr queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dual_issue_instr_queue;

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    logic             clk_i = 1'b0;
    logic             reset_n_i;
    logic [1:0]       enq_cnt_i;
    logic [1:0][31:0] enq_instr_i;
    logic [31:0]      enq_pc_i;
    logic             enq_ready_o;
    logic [1:0][31:0] instr_o;
    logic [31:0]      pc_o;
    logic [1:0]       v_o;
    logic [1:0]       deq_cnt_i;
    logic             flush_i;
    logic [3:0]       count_o;
    logic             overflow_o;
    logic             underflow_o;

    int n_tests = 0;
    int n_fail  = 0;

    dual_issue_instr_queue #(.DEPTH_P(8), .INSTR_WIDTH_P(32)) dut (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .enq_cnt_i   (enq_cnt_i),
        .enq_instr_i (enq_instr_i),
        .enq_pc_i    (enq_pc_i),
        .enq_ready_o (enq_ready_o),
        .instr_o     (instr_o),
        .pc_o        (pc_o),
        .v_o         (v_o),
        .deq_cnt_i   (deq_cnt_i),
        .flush_i     (flush_i),
        .count_o     (count_o),
        .overflow_o  (overflow_o),
        .underflow_o (underflow_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  enq;
        logic [31:0] i0, i1, pc;
        logic [1:0]  deq;
        logic        fl;
        logic [1:0]  ev;
        logic [31:0] ei0, ei1, epc;
        logic [3:0]  ecnt;
        logic        erdy, eovf, eunf;
    } vec_t;

    function automatic vec_t mk(input int e, input int a, input int b, input int pc,
                                input int d, input int f, input int ev, input int ea,
                                input int eb, input int epc, input int ec,
                                input int r, input int o, input int u);
        vec_t v;
        v.enq = 2'(e);  v.i0 = 32'(a);  v.i1 = 32'(b);  v.pc = 32'(pc);
        v.deq = 2'(d);  v.fl = 1'(f);   v.ev = 2'(ev);
        v.ei0 = 32'(ea); v.ei1 = 32'(eb); v.epc = 32'(epc);
        v.ecnt = 4'(ec); v.erdy = 1'(r); v.eovf = 1'(o); v.eunf = 1'(u);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [1:0] e, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [1:0] d, input logic f);
        enq_cnt_i = e; enq_instr_i[0] = a; enq_instr_i[1] = b;
        enq_pc_i = pc; deq_cnt_i = d; flush_i = f;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".v"},     64'(v_o),         64'd0);
        chk({tag, ".i0"},    64'(instr_o[0]),  64'(c_NOP));
        chk({tag, ".i1"},    64'(instr_o[1]),  64'(c_NOP));
        chk({tag, ".cnt"},   64'(count_o),     64'd0);
        chk({tag, ".rdy"},   64'(enq_ready_o), 64'd1);
        chk({tag, ".ovf"},   64'(overflow_o),  64'd0);
        chk({tag, ".unf"},   64'(underflow_o), 64'd0);
    endtask

    vec_t vecs[19];

    initial begin
        // Letters A..V are 0x101..0x116; NOP slots expect 0x13.
        vecs[0]  = mk(2, 'h101, 'h102, 'h100, 0, 0, 3, 'h101, 'h102, 'h100, 2, 1, 0, 0);
        vecs[1]  = mk(1, 'h103, 'h0,   'h108, 0, 0, 3, 'h101, 'h102, 'h100, 3, 1, 0, 0);
        vecs[2]  = mk(0, 'h0,   'h0,   'h0,   1, 0, 3, 'h102, 'h103, 'h104, 2, 1, 0, 0);
        vecs[3]  = mk(0, 'h0,   'h0,   'h0,   2, 0, 0, 'h13,  'h13,  'h0,   0, 1, 0, 0);
        vecs[4]  = mk(2, 'h104, 'h105, 'h200, 0, 0, 3, 'h104, 'h105, 'h200, 2, 1, 0, 0);
        vecs[5]  = mk(2, 'h106, 'h107, 'h300, 1, 0, 3, 'h105, 'h106, 'h204, 3, 1, 0, 0);
        vecs[6]  = mk(2, 'h108, 'h109, 'h400, 0, 0, 3, 'h105, 'h106, 'h204, 5, 1, 0, 0);
        vecs[7]  = mk(2, 'h10a, 'h10b, 'h500, 0, 0, 3, 'h105, 'h106, 'h204, 7, 0, 0, 0);
        vecs[8]  = mk(2, 'h10c, 'h10d, 'h600, 2, 0, 3, 'h107, 'h108, 'h304, 5, 1, 1, 0);
        vecs[9]  = mk(0, 'h0,   'h0,   'h0,   0, 0, 3, 'h107, 'h108, 'h304, 5, 1, 1, 0);
        vecs[10] = mk(0, 'h0,   'h0,   'h0,   2, 0, 3, 'h109, 'h10a, 'h404, 3, 1, 1, 0);
        vecs[11] = mk(0, 'h0,   'h0,   'h0,   2, 0, 1, 'h10b, 'h13,  'h504, 1, 1, 1, 0);
        vecs[12] = mk(0, 'h0,   'h0,   'h0,   2, 0, 0, 'h13,  'h13,  'h0,   0, 1, 1, 1);
        vecs[13] = mk(2, 'h10e, 'h10f, 'h600, 0, 0, 3, 'h10e, 'h10f, 'h600, 2, 1, 1, 1);
        vecs[14] = mk(1, 'h110, 'h0,   'h608, 0, 0, 3, 'h10e, 'h10f, 'h600, 3, 1, 1, 1);
        vecs[15] = mk(2, 'h111, 'h112, 'h60c, 0, 0, 3, 'h10e, 'h10f, 'h600, 5, 1, 1, 1);
        vecs[16] = mk(2, 'h113, 'h114, 'h700, 1, 1, 0, 'h13,  'h13,  'h0,   0, 1, 1, 1);
        vecs[17] = mk(2, 'h115, 'h116, 'h800, 0, 0, 3, 'h115, 'h116, 'h800, 2, 1, 1, 1);
        vecs[18] = mk(0, 'h0,   'h0,   'h0,   1, 0, 1, 'h116, 'h13,  'h804, 1, 1, 1, 1);

        reset_n_i = 1'b0;
        drive(2'd0, 32'd0, 32'd0, 32'd0, 2'd0, 1'b0);
        repeat (2) @(posedge clk_i);
        #1;
        chk_reset_vals("por");
        reset_n_i = 1'b1;

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].enq, vecs[i].i0, vecs[i].i1, vecs[i].pc, vecs[i].deq, vecs[i].fl);
            @(posedge clk_i);
            #1;
            chk($sformatf("vec%0d.v", i),   64'(v_o),         64'(vecs[i].ev));
            chk($sformatf("vec%0d.i0", i),  64'(instr_o[0]),  64'(vecs[i].ei0));
            chk($sformatf("vec%0d.i1", i),  64'(instr_o[1]),  64'(vecs[i].ei1));
            if (vecs[i].ev[0])
                chk($sformatf("vec%0d.pc", i), 64'(pc_o), 64'(vecs[i].epc));
            chk($sformatf("vec%0d.cnt", i), 64'(count_o),     64'(vecs[i].ecnt));
            chk($sformatf("vec%0d.rdy", i), 64'(enq_ready_o), 64'(vecs[i].erdy));
            chk($sformatf("vec%0d.ovf", i), 64'(overflow_o),  64'(vecs[i].eovf));
            chk($sformatf("vec%0d.unf", i), 64'(underflow_o), 64'(vecs[i].eunf));
        end

        // Asynchronous reset mid-cycle, observed before the next edge.
        drive(2'd0, 32'd0, 32'd0, 32'd0, 2'd0, 1'b0);
        reset_n_i = 1'b0;
        #1;
        chk_reset_vals("arst");
        #2;
        reset_n_i = 1'b1;

        // Push must not reach the outputs before the edge; enq of 3 is illegal.
        drive(2'd2, 32'h201, 32'h202, 32'h900, 2'd0, 1'b0);
        #1;
        chk("comb.v",   64'(v_o),     64'd0);
        chk("comb.cnt", 64'(count_o), 64'd0);
        @(posedge clk_i); #1;
        chk("enq.i0",  64'(instr_o[0]), 64'h201);
        chk("enq.pc",  64'(pc_o),       64'h900);
        drive(2'd3, 32'h203, 32'h204, 32'h908, 2'd0, 1'b0);
        @(posedge clk_i); #1;
        chk("enq3.cnt", 64'(count_o),    64'd2);
        chk("enq3.ovf", 64'(overflow_o), 64'd1);
        chk("enq3.i1",  64'(instr_o[1]), 64'h202);

        // Flush overriding an over-dequeue must not raise underflow.
        drive(2'd0, 32'd0, 32'd0, 32'd0, 2'd0, 1'b0);
        reset_n_i = 1'b0;
        #1;
        reset_n_i = 1'b1;
        drive(2'd0, 32'd0, 32'd0, 32'd0, 2'd2, 1'b1);
        @(posedge clk_i); #1;
        chk("flush.unf", 64'(underflow_o), 64'd0);
        chk("flush.cnt", 64'(count_o),     64'd0);

        // Sustained dual push / dual pop across pointer wrap.
        drive(2'd2, 32'hD000_0000, 32'hD000_0001, 32'h1000, 2'd0, 1'b0);
        @(posedge clk_i); #1;
        for (int k = 1; k <= 20; k++) begin
            drive(2'd2, 32'hD000_0000 + 32'(2*k), 32'hD000_0001 + 32'(2*k),
                  32'h1000 + 32'(8*k), 2'd2, 1'b0);
            @(posedge clk_i); #1;
            chk($sformatf("sus%0d.cnt", k), 64'(count_o),    64'd2);
            chk($sformatf("sus%0d.i0", k),  64'(instr_o[0]), 64'(32'hD000_0000 + 32'(2*k)));
            chk($sformatf("sus%0d.i1", k),  64'(instr_o[1]), 64'(32'hD000_0001 + 32'(2*k)));
            chk($sformatf("sus%0d.pc", k),  64'(pc_o),       64'(32'h1000 + 32'(8*k)));
        end
        chk("sus.ovf", 64'(overflow_o),  64'd0);
        chk("sus.unf", 64'(underflow_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dual_issue_instr_queue.md
DUAL_ISSUE_INSTR_QUEUE -- requirements
Module: dual_issue_instr_queue

Interface
REQ-001 Parameter DEPTH_P, default 8, SHALL set the entry count; it SHALL be a power of two, >= 4.
REQ-002 Parameter INSTR_WIDTH_P, default 32, SHALL set the instruction width.
REQ-003 Port clk_i, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset_n_i, input, 1, SHALL be an asynchronous, active-low reset.
REQ-005 Port enq_cnt_i, input, 2, SHALL give the number of fetched instructions pushed this cycle; legal values are 0, 1 and 2.
REQ-006 Port enq_instr_i, input, 2 x INSTR_WIDTH_P, SHALL carry the fetched words; [0] is older.
REQ-007 Port enq_pc_i, input, 32, SHALL give the PC of enq_instr_i[0]; [1] SHALL be at enq_pc_i+4.
REQ-008 Port enq_ready_o, output, 1, SHALL mean two free entries exist.
REQ-009 Port instr_o, output, 2 x INSTR_WIDTH_P, SHALL drive the head pair to the dual-issue decoder; [0] is older.
REQ-010 Port pc_o, output, 32, SHALL give the PC of instr_o[0].
REQ-011 Port v_o, output, 2, SHALL carry per-slot valid bits for instr_o.
REQ-012 Port deq_cnt_i, input, 2, SHALL give the instructions consumed this cycle: 0 = stall, 1 = single-issue, 2 = dual-issue.
REQ-013 Port flush_i, input, 1, SHALL discard all entries (redirect).
REQ-014 Port count_o, output, $clog2(DEPTH_P)+1, SHALL give the occupied entry count.
REQ-015 Port overflow_o, output, 1, SHALL be a sticky error flag.
REQ-016 Port underflow_o, output, 1, SHALL be a sticky error flag.

Function
REQ-017 Storage SHALL be a circular buffer of {instr, pc}, with read/write pointers of $clog2(DEPTH_P) bits wrapping modulo DEPTH_P.
REQ-018 instr_o[k] SHALL be mem[(rd_ptr+k) mod DEPTH_P] combinationally; pc_o SHALL be the pc of mem[rd_ptr].
REQ-019 v_o[0] SHALL be (count>=1) and v_o[1] SHALL be (count>=2).
REQ-020 Any slot with v_o[k]=0 SHALL drive instr_o[k]=32'h00000013 (NOP).
REQ-021 enq_ready_o SHALL be (DEPTH_P - count >= 2), computed from registered count only; same-cycle dequeue SHALL NOT raise it.
REQ-022 Enqueue handling:
 - enq_cnt_i=n with enq_ready_o=1 SHALL write n entries at wr_ptr; the second entry's pc SHALL be enq_pc_i+4.
 - wr_ptr SHALL advance by n.
REQ-023 Illegal enqueue (enq_cnt_i>0 with enq_ready_o=0, or enq_cnt_i=3):
 - no entry SHALL be written;
 - overflow_o SHALL be set on the next edge.
REQ-024 Dequeue handling:
 - the effective dequeue SHALL be min(deq_cnt_i, count);
 - rd_ptr SHALL advance by the effective value;
 - if deq_cnt_i>count, underflow_o SHALL be set on the next edge.
REQ-025 Simultaneous enqueue and dequeue SHALL give count_next = count + enq_eff - deq_eff within one cycle.
REQ-026 A single-issue dequeue SHALL make the old instr_o[1] appear as instr_o[0] on the next cycle (shift by one).
REQ-027 Latency:
 - an entry enqueued at edge T SHALL be visible on instr_o/v_o after edge T;
 - there SHALL be no combinational path from enq_* to instr_o, v_o or pc_o.
REQ-028 Flush:
 - flush_i=1 SHALL set rd_ptr=wr_ptr=0 and count=0 at the next edge;
 - flush_i SHALL override same-cycle enqueue and dequeue;
 - it SHALL NOT set or clear overflow_o or underflow_o.
REQ-029 Full/empty: count=DEPTH_P means full and count=0 means empty; with DEPTH_P-1 occupied, enq_ready_o SHALL be 0.
REQ-030 overflow_o and underflow_o SHALL remain set until reset.

Reset
REQ-031 reset_n_i low SHALL asynchronously force:
 - rd_ptr=0, wr_ptr=0, count_o=0;
 - v_o=2'b00 and instr_o=NOP;
 - enq_ready_o=1, overflow_o=0, underflow_o=0.
REQ-032 Reset asserted mid-operation SHALL discard all entries, with no partial writes visible after release.
REQ-033 Storage contents SHALL need no reset.

Verification
REQ-034 Empty queue, enq_cnt_i=2, instrs {A,B}, enq_pc_i=0x100 -> next cycle v_o=2'b11, instr_o={A,B}, pc_o=0x100, count_o=2.
REQ-035 Queue holds {A,B,C}, deq_cnt_i=1 -> instr_o={B,C}, pc_o=0x104, count_o=2; then deq_cnt_i=2 -> v_o=2'b00, instr_o={NOP,NOP}.
REQ-036 DEPTH_P=8, count=7, enq_cnt_i=2 with deq_cnt_i=2 same cycle -> nothing written, overflow_o=1, count_o=5.
REQ-037 count=1, deq_cnt_i=2 -> count_o=0, underflow_o=1, rd_ptr advances by 1.
REQ-038 Sustained enq 2/deq 2 for 20 cycles from count=2 -> pointers wrap past 7->0, data order preserved, count_o stays 2.
REQ-039 count=5 with flush_i=1 and enq_cnt_i=2 same cycle -> count_o=0, v_o=0; then reset_n_i pulsed low asynchronously -> all outputs at REQ-031 values before the next edge.
